t_node_sched: RTL

//  Registered, stateful scheduler for one BFT t-switch node (level >= 1).

---
 rtl/bft_pkg.sv | 36 +++
 rtl/t_node_sched_if.sv | 33 +++
 rtl/t_route_dec.sv | 47 ++++
 rtl/t_node_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/bft_pkg.sv
// ----------------------------------------------------------------------------
// bft_pkg
// Shared definitions for the BFT t-switch node scheduler.
//  - dir_e : 2-bit route direction (VOID/LEFT/RIGHT/UP), same encoding as the
//            shared direction parameters used elsewhere in the tree.
//  - packet field offsets: a packet is {valid, addr[N_ADDR-1:0], data[D_W-1:0]}.
//    The offsets depend on the node parameters, so they are constant functions.
// ----------------------------------------------------------------------------
package bft_pkg;

    typedef enum logic [1:0] {
        VOID  = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10,
        UP    = 2'b11
    } dir_e;

    localparam int DATA_LSB = 0;

    function automatic int pkt_w(input int n_addr, input int d_w);
        return 1 + n_addr + d_w;
    endfunction

    function automatic int valid_bit(input int n_addr, input int d_w);
        return n_addr + d_w;
    endfunction

    function automatic int addr_msb(input int n_addr, input int d_w);
        return n_addr + d_w - 1;
    endfunction

    function automatic int addr_lsb(input int d_w);
        return d_w;
    endfunction

endpackage

// File: rtl/t_node_sched_if.sv
// ----------------------------------------------------------------------------
// t_node_sched_if
// Packet buses around one t-switch node.
//  l_bus_i / r_bus_i / u_bus_i : packets arriving from left child, right child
//                                and parent
//  l_bus_o / r_bus_o / u_bus_o : packets leaving toward left child, right child
//                                and parent
// Modports:
//  slave  : the node itself (consumes *_i, produces *_o)
//  master : the surrounding links (produce *_i, consume *_o)
// ----------------------------------------------------------------------------
interface t_node_sched_if #(
    parameter int P_W = 37
) ();

    logic [P_W-1:0] l_bus_i;
    logic [P_W-1:0] r_bus_i;
    logic [P_W-1:0] u_bus_i;
    logic [P_W-1:0] l_bus_o;
    logic [P_W-1:0] r_bus_o;
    logic [P_W-1:0] u_bus_o;

    modport slave (
        input  l_bus_i, r_bus_i, u_bus_i,
        output l_bus_o, r_bus_o, u_bus_o
    );

    modport master (
        output l_bus_i, r_bus_i, u_bus_i,
        input  l_bus_o, r_bus_o, u_bus_o
    );

endinterface

// File: rtl/t_route_dec.sv
// ----------------------------------------------------------------------------
// t_route_dec
// Route decoder for one input packet of a t-switch node.
//  i_addr  : destination leaf address
//  i_valid : packet valid bit
//  o_dir   : VOID when not valid; UP when the address lies outside this
//            node's subtree; otherwise LEFT/RIGHT from addr[LEVEL-1].
// The top node (LEVEL == N_ADDR) owns the whole tree, so nothing goes UP.
// ----------------------------------------------------------------------------
module t_route_dec
    import bft_pkg::*;
#(
    parameter int N_ADDR = 4,
    parameter int LEVEL  = 1,
    parameter int POS    = 0
) (
    input  logic [N_ADDR-1:0] i_addr,
    input  logic              i_valid,
    output dir_e              o_dir
);

    logic w_in_sub;

    generate
        if (LEVEL >= N_ADDR) begin : g_top
            assign w_in_sub = 1'b1;
        end else begin : g_sub
            localparam int             HW    = N_ADDR - LEVEL;
            localparam logic [HW-1:0]  POS_V = HW'(POS);
            assign w_in_sub = (i_addr[N_ADDR-1:LEVEL] == POS_V);
        end
    endgenerate

    always_comb begin
        o_dir = VOID;
        if (i_valid) begin
            if (!w_in_sub) begin
                o_dir = UP;
            end else if (i_addr[LEVEL-1]) begin
                o_dir = RIGHT;
            end else begin
                o_dir = LEFT;
            end
        end
    end

endmodule

// File: rtl/t_node_sched.sv
// ----------------------------------------------------------------------------
// t_node_sched
// Registered deflection scheduler for one BFT t-switch node (level >= 1).
// Every valid input packet is placed on exactly one output bus; packets that
// cannot get their decoded port are deflected rather than dropped. One cycle
// of latency. Uplink contention between left and right alternates through a
// round-robin bit.
// Ports:
//  clk      : clock, all state on rising edge
//  reset    : synchronous, active-high; clears outputs, rr and counter
//  nbus     : t_node_sched_if.slave, the three input and three output buses
//  defl_cnt : saturating deflection count
// Optional feature:
//  T_DEFL_CNT_EN defined   -> defl_cnt counts deflections (saturating)
//  T_DEFL_CNT_EN undefined -> no counter, defl_cnt is constant 0
// ----------------------------------------------------------------------------
module t_node_sched
    import bft_pkg::*;
#(
    parameter int N_ADDR = 4,
    parameter int D_W    = 32,
    parameter int LEVEL  = 1,
    parameter int POS    = 0
) (
    input  logic                clk,
    input  logic                reset,
    t_node_sched_if.slave       nbus,
    output logic [15:0]         defl_cnt
);

    localparam int P_W      = pkt_w(N_ADDR, D_W);
    localparam int VLD_BIT  = valid_bit(N_ADDR, D_W);
    localparam int ADDR_MSB = addr_msb(N_ADDR, D_W);

    // Free-port mask bit order: [0]=LEFT, [1]=RIGHT, [2]=UP
    function automatic logic is_free(input logic [2:0] free, input dir_e port);
        case (port)
            LEFT:    return free[0];
            RIGHT:   return free[1];
            UP:      return free[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] take(input logic [2:0] free, input dir_e port);
        logic [2:0] f;
        f = free;
        case (port)
            LEFT:    f[0] = 1'b0;
            RIGHT:   f[1] = 1'b0;
            UP:      f[2] = 1'b0;
            default: f = free;
        endcase
        return f;
    endfunction

    // Desired port, else arrival port, else whichever port is still free.
    function automatic dir_e pick(input dir_e want, input dir_e arrive,
                                  input logic [2:0] free);
        if (is_free(free, want))   return want;
        if (is_free(free, arrive)) return arrive;
        if (free[0])               return LEFT;
        if (free[1])               return RIGHT;
        return UP;
    endfunction

    function automatic logic [P_W-1:0] mux_port(
        input dir_e port,
        input dir_e dst_l, input dir_e dst_r, input dir_e dst_u,
        input logic [P_W-1:0] pk_l, input logic [P_W-1:0] pk_r,
        input logic [P_W-1:0] pk_u);
        if (dst_l == port) return pk_l;
        if (dst_r == port) return pk_r;
        if (dst_u == port) return pk_u;
        return '0;
    endfunction

    dir_e           w_dir_l, w_dir_r, w_dir_u;
    dir_e           w_dst_l, w_dst_r, w_dst_u;
    logic [2:0]     w_free;
    logic           w_need_l, w_need_r;
    logic           w_rr_toggle;
    logic [P_W-1:0] w_l_nxt, w_r_nxt, w_u_nxt;

    logic [P_W-1:0] r_l_bus_p1, r_r_bus_p1, r_u_bus_p1;
    logic           r_rr;

    t_route_dec #(.N_ADDR(N_ADDR), .LEVEL(LEVEL), .POS(POS)) u_dec_l (
        .i_addr  (nbus.l_bus_i[ADDR_MSB -: N_ADDR]),
        .i_valid (nbus.l_bus_i[VLD_BIT]),
        .o_dir   (w_dir_l)
    );

    t_route_dec #(.N_ADDR(N_ADDR), .LEVEL(LEVEL), .POS(POS)) u_dec_r (
        .i_addr  (nbus.r_bus_i[ADDR_MSB -: N_ADDR]),
        .i_valid (nbus.r_bus_i[VLD_BIT]),
        .o_dir   (w_dir_r)
    );

    t_route_dec #(.N_ADDR(N_ADDR), .LEVEL(LEVEL), .POS(POS)) u_dec_u (
        .i_addr  (nbus.u_bus_i[ADDR_MSB -: N_ADDR]),
        .i_valid (nbus.u_bus_i[VLD_BIT]),
        .o_dir   (w_dir_u)
    );

    // Stage p0: port assignment, evaluated in strict priority order with a
    // running free-port mask.
    always_comb begin
        w_free  = 3'b111;
        w_dst_l = VOID;
        w_dst_r = VOID;
        w_dst_u = VOID;

        // Turnbacks claim their own arrival port first.
        if (w_dir_l == LEFT) begin
            w_dst_l = LEFT;
            w_free  = take(w_free, LEFT);
        end
        if (w_dir_r == RIGHT) begin
            w_dst_r = RIGHT;
            w_free  = take(w_free, RIGHT);
        end
        if (w_dir_u == UP) begin
            w_dst_u = UP;
            w_free  = take(w_free, UP);
        end

        // Downlink: UP is always still free here because u did not turn back.
        if (w_dir_u == LEFT || w_dir_u == RIGHT) begin
            w_dst_u = is_free(w_free, w_dir_u) ? w_dir_u : UP;
            w_free  = take(w_free, w_dst_u);
        end

        w_need_l = (w_dir_l == RIGHT) || (w_dir_l == UP);
        w_need_r = (w_dir_r == LEFT)  || (w_dir_r == UP);

        if (!r_rr) begin
            if (w_need_l) begin
                w_dst_l = pick(w_dir_l, LEFT, w_free);
                w_free  = take(w_free, w_dst_l);
            end
            if (w_need_r) begin
                w_dst_r = pick(w_dir_r, RIGHT, w_free);
                w_free  = take(w_free, w_dst_r);
            end
        end else begin
            if (w_need_r) begin
                w_dst_r = pick(w_dir_r, RIGHT, w_free);
                w_free  = take(w_free, w_dst_r);
            end
            if (w_need_l) begin
                w_dst_l = pick(w_dir_l, LEFT, w_free);
                w_free  = take(w_free, w_dst_l);
            end
        end
    end

    assign w_rr_toggle = (w_dir_l == UP) && (w_dir_r == UP);

    assign w_l_nxt = mux_port(LEFT,  w_dst_l, w_dst_r, w_dst_u,
                              nbus.l_bus_i, nbus.r_bus_i, nbus.u_bus_i);
    assign w_r_nxt = mux_port(RIGHT, w_dst_l, w_dst_r, w_dst_u,
                              nbus.l_bus_i, nbus.r_bus_i, nbus.u_bus_i);
    assign w_u_nxt = mux_port(UP,    w_dst_l, w_dst_r, w_dst_u,
                              nbus.l_bus_i, nbus.r_bus_i, nbus.u_bus_i);

    // Stage p1: registered outputs and round-robin state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_l_bus_p1 <= '0;
            r_r_bus_p1 <= '0;
            r_u_bus_p1 <= '0;
            r_rr       <= 1'b0;
        end else begin
            r_l_bus_p1 <= w_l_nxt;
            r_r_bus_p1 <= w_r_nxt;
            r_u_bus_p1 <= w_u_nxt;
            if (w_rr_toggle) begin
                r_rr <= ~r_rr;
            end
        end
    end

    assign nbus.l_bus_o = r_l_bus_p1;
    assign nbus.r_bus_o = r_r_bus_p1;
    assign nbus.u_bus_o = r_u_bus_p1;

`ifdef T_DEFL_CNT_EN
    function automatic logic [15:0] sat_add(input logic [15:0] cnt,
                                            input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, cnt} + 17'(inc);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic        w_defl_l, w_defl_r, w_defl_u;
    logic [1:0]  w_ndefl;
    logic [15:0] r_defl_cnt;

    assign w_defl_l = (w_dir_l != VOID) && (w_dst_l != w_dir_l);
    assign w_defl_r = (w_dir_r != VOID) && (w_dst_r != w_dir_r);
    assign w_defl_u = (w_dir_u != VOID) && (w_dst_u != w_dir_u);
    assign w_ndefl  = 2'(w_defl_l) + 2'(w_defl_r) + 2'(w_defl_u);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_defl_cnt <= '0;
        end else begin
            r_defl_cnt <= sat_add(r_defl_cnt, w_ndefl);
        end
    end

    assign defl_cnt = r_defl_cnt;
`else
    assign defl_cnt = 16'h0000;
`endif

endmodule
